// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: two writeback sources share one registered port.
// Define WB_RR_EN for round-robin arbitration; otherwise source 0 has fixed priority.
module regfile_wb_arbiter #(
   parameter int n       = 32,
   parameter int address = 5,
   parameter int cw      = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               src0_valid_i,
   input  logic [address-1:0] src0_addr_i,
   input  logic [n-1:0]       src0_data_i,
   output logic               src0_ready_o,
   input  logic               src1_valid_i,
   input  logic [address-1:0] src1_addr_i,
   input  logic [n-1:0]       src1_data_i,
   output logic               src1_ready_o,
   output logic               rd_wr_o,
   output logic [address-1:0] rd_addr_o,
   output logic [n-1:0]       rd_data_o,
   output logic [cw-1:0]      wr_cnt_o
);

   logic               w_real0;
   logic               w_real1;
   logic               w_null0;
   logic               w_null1;
   logic               w_gnt0;
   logic               w_gnt1;
   logic               w_rdy0;
   logic               w_rdy1;

   logic               r_wr;
   logic [address-1:0] r_addr;
   logic [n-1:0]       r_data;
   logic [cw-1:0]      r_cnt;
`ifdef WB_RR_EN
   logic               r_ptr;
`endif

   // Classify requests, pick at most one winner and form the ready handshakes.
   always_comb begin
      w_real0 = 1'b0;
      w_real1 = 1'b0;
      w_null0 = 1'b0;
      w_null1 = 1'b0;
      w_gnt0  = 1'b0;
      w_gnt1  = 1'b0;
      w_rdy0  = 1'b0;
      w_rdy1  = 1'b0;
      if (rst_i) begin
         w_real0 = src0_valid_i && (src0_addr_i != {address{1'b0}});
         w_real1 = src1_valid_i && (src1_addr_i != {address{1'b0}});
         w_null0 = src0_valid_i && (src0_addr_i == {address{1'b0}});
         w_null1 = src1_valid_i && (src1_addr_i == {address{1'b0}});
`ifdef WB_RR_EN
         // r_ptr=0 favours source 0 on a contested cycle.
         w_gnt0  = w_real0 && (!w_real1 || !r_ptr);
         w_gnt1  = w_real1 && (!w_real0 ||  r_ptr);
`else
         w_gnt0  = w_real0;
         w_gnt1  = w_real1 && !w_real0;
`endif
         w_rdy0  = w_null0 || w_gnt0;
         w_rdy1  = w_null1 || w_gnt1;
      end else begin
         w_rdy0  = 1'b0;
         w_rdy1  = 1'b0;
      end
   end

   // Output stage: capture the winner, pulse write-enable, count committed writes.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_wr   <= 1'b0;
         r_addr <= {address{1'b0}};
         r_data <= {n{1'b0}};
         r_cnt  <= {cw{1'b0}};
      end else begin
         r_wr <= w_gnt0 || w_gnt1;
         if (w_gnt0) begin
            r_addr <= src0_addr_i;
            r_data <= src0_data_i;
         end else if (w_gnt1) begin
            r_addr <= src1_addr_i;
            r_data <= src1_data_i;
         end else begin
            r_addr <= r_addr;
            r_data <= r_data;
         end
         if (w_gnt0 || w_gnt1) begin
            r_cnt <= r_cnt + {{(cw-1){1'b0}}, 1'b1};
         end else begin
            r_cnt <= r_cnt;
         end
      end
   end

`ifdef WB_RR_EN
   // Round-robin pointer: after a grant the other source becomes favoured.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_ptr <= 1'b0;
      end else if (w_gnt0) begin
         r_ptr <= 1'b1;
      end else if (w_gnt1) begin
         r_ptr <= 1'b0;
      end else begin
         r_ptr <= r_ptr;
      end
   end
`endif

   assign src0_ready_o = w_rdy0;
   assign src1_ready_o = w_rdy1;
   assign rd_wr_o      = r_wr;
   assign rd_addr_o    = r_addr;
   assign rd_data_o    = r_data;
   assign wr_cnt_o     = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a request-level model predicts handshakes and port writes.
module tb_regfile_wb_arbiter;

   localparam int N  = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          src0_valid;
   logic [AW-1:0] src0_addr;
   logic [N-1:0]  src0_data;
   logic          src0_ready;
   logic          src1_valid;
   logic [AW-1:0] src1_addr;
   logic [N-1:0]  src1_data;
   logic          src1_ready;
   logic          rd_wr;
   logic [AW-1:0] rd_addr;
   logic [N-1:0]  rd_data;
   logic [CW-1:0] wr_cnt;

   regfile_wb_arbiter #(.n(N), .address(AW), .cw(CW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .src0_valid_i (src0_valid),
      .src0_addr_i  (src0_addr),
      .src0_data_i  (src0_data),
      .src0_ready_o (src0_ready),
      .src1_valid_i (src1_valid),
      .src1_addr_i  (src1_addr),
      .src1_data_i  (src1_data),
      .src1_ready_o (src1_ready),
      .rd_wr_o      (rd_wr),
      .rd_addr_o    (rd_addr),
      .rd_data_o    (rd_data),
      .wr_cnt_o     (wr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [N-1:0]  d;
      logic [CW-1:0] c;
   } wr_t;

   wr_t q[$];
   int  total = 0;
   int  bad   = 0;
   bit  mon_en = 1'b0;

   // Pending request held by each source until it is accepted.
   bit            p_v[2];
   logic [AW-1:0] p_a[2];
   logic [N-1:0]  p_d[2];

   // Reference state: favoured source, committed count, visible port state.
   int            m_fav = 0;
   int            m_cnt = 0;
   logic [AW-1:0] m_last_a = '0;
   logic [N-1:0]  m_last_d = '0;
   logic [CW-1:0] m_vis_cnt = '0;

   task automatic set_req(input int k, input bit v, input logic [AW-1:0] a, input logic [N-1:0] d);
      p_v[k] = v;
      p_a[k] = a;
      p_d[k] = d;
   endtask

   task automatic step(input logic rst_v);
      bit  real_r[2];
      bit  null_r[2];
      bit  exp_rdy[2];
      bit  got_rdy[2];
      int  win;
      wr_t e;
      @(negedge clk);
      rst        = rst_v;
      src0_valid = p_v[0];
      src0_addr  = p_a[0];
      src0_data  = p_d[0];
      src1_valid = p_v[1];
      src1_addr  = p_a[1];
      src1_data  = p_d[1];
      #1;
      win = -1;
      for (int k = 0; k < 2; k++) begin
         real_r[k]  = p_v[k] && (p_a[k] != 0);
         null_r[k]  = p_v[k] && (p_a[k] == 0);
         exp_rdy[k] = 1'b0;
      end
      if (rst_v) begin
         if (real_r[0] && real_r[1]) begin
`ifdef WB_RR_EN
            win = m_fav;
`else
            win = 0;
`endif
         end else if (real_r[0]) begin
            win = 0;
         end else if (real_r[1]) begin
            win = 1;
         end
         for (int k = 0; k < 2; k++) exp_rdy[k] = null_r[k] || (win == k);
      end
      got_rdy[0] = src0_ready;
      got_rdy[1] = src1_ready;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (got_rdy[k] !== exp_rdy[k]) begin
            bad++;
            $display("FAIL ready%0d t=%0t got=%b want=%b", k, $time, got_rdy[k], exp_rdy[k]);
         end
      end
      if (!rst_v) begin
         m_fav     = 0;
         m_cnt     = 0;
         m_last_a  = '0;
         m_last_d  = '0;
         m_vis_cnt = '0;
      end else begin
         if (win >= 0) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            e.a = p_a[win];
            e.d = p_d[win];
            e.c = CW'(m_cnt);
            q.push_back(e);
            m_fav = 1 - win;
         end
         for (int k = 0; k < 2; k++) if (exp_rdy[k]) p_v[k] = 1'b0;
      end
   endtask

   // Monitor: every port write must match the oldest predicted write; idle cycles must hold state.
   always @(negedge clk) begin
      wr_t e;
      if (mon_en) begin
         total++;
         if (rd_wr) begin
            if (q.size() == 0) begin
               bad++;
               $display("FAIL extra_write t=%0t got addr=%0d data=%h", $time, rd_addr, rd_data);
            end else begin
               e = q.pop_front();
               if (rd_addr !== e.a || rd_data !== e.d || wr_cnt !== e.c) begin
                  bad++;
                  $display("FAIL port_write t=%0t got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                           $time, rd_addr, rd_data, wr_cnt, e.a, e.d, e.c);
               end
               m_last_a  = e.a;
               m_last_d  = e.d;
               m_vis_cnt = e.c;
            end
         end else if (q.size() != 0) begin
            e = q.pop_front();
            bad++;
            $display("FAIL missing_write t=%0t want a=%0d d=%h c=%0d", $time, e.a, e.d, e.c);
            m_last_a  = e.a;
            m_last_d  = e.d;
            m_vis_cnt = e.c;
         end else if (rd_addr !== m_last_a || rd_data !== m_last_d || wr_cnt !== m_vis_cnt) begin
            bad++;
            $display("FAIL idle_hold t=%0t got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                     $time, rd_addr, rd_data, wr_cnt, m_last_a, m_last_d, m_vis_cnt);
         end
      end
   end

   initial begin
      rst = 1'b0;
      src0_valid = 1'b0; src0_addr = '0; src0_data = '0;
      src1_valid = 1'b0; src1_addr = '0; src1_data = '0;
      for (int k = 0; k < 2; k++) set_req(k, 1'b0, '0, '0);

      // Reset with both sources requesting x5.
      set_req(0, 1'b1, 5'd5, 32'h0000_0055);
      set_req(1, 1'b1, 5'd5, 32'h0000_0505);
      step(1'b0);
      step(1'b0);
      mon_en = 1'b1;
      set_req(0, 1'b0, '0, '0);
      set_req(1, 1'b0, '0, '0);

      // Single write.
      set_req(0, 1'b1, 5'd3, 32'hDEAD_BEEF);
      repeat (3) step(1'b1);

      // Contention from reset.
      set_req(0, 1'b1, 5'd1, 32'h0000_0011);
      set_req(1, 1'b1, 5'd2, 32'h0000_0022);
      step(1'b0);
      repeat (3) step(1'b1);

      // Fixed-priority starvation: source 0 re-issues every cycle.
      set_req(1, 1'b1, 5'd4, 32'h0000_0044);
      for (int i = 0; i < 4; i++) begin
         set_req(0, 1'b1, AW'(10 + i), $urandom);
         step(1'b1);
      end
      repeat (2) step(1'b1);

      // x0 drop alongside a real write.
      set_req(0, 1'b1, 5'd0, 32'h0000_0055);
      set_req(1, 1'b1, 5'd7, 32'h0000_0007);
      repeat (2) step(1'b1);

      // Reset right after a grant.
      set_req(1, 1'b1, 5'd9, 32'h0000_0099);
      step(1'b1);
      step(1'b0);
      repeat (2) step(1'b1);

      // Counter wrap: 17 consecutive writes from source 0.
      step(1'b0);
      for (int i = 0; i < 17; i++) begin
         set_req(0, 1'b1, AW'(1 + (i % 31)), $urandom);
         step(1'b1);
      end
      repeat (2) step(1'b1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 2; k++) begin
            if (!p_v[k] && $urandom_range(0, 3) != 0) begin
               if ($urandom_range(0, 4) == 0) set_req(k, 1'b1, '0, $urandom);
               else set_req(k, 1'b1, AW'($urandom_range(1, 31)), $urandom);
            end
         end
         step(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
      end

      set_req(0, 1'b0, '0, '0);
      set_req(1, 1'b0, '0, '0);
      repeat (3) step(1'b1);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d pending want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
